mem_bus_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the on-chip BRAM memory bus.
- Shares one BRAM controller between the instruction-fetch port (m0) and the load/store port (m1).
- All ports use the valid/ready/addr/wdata/wstrb/rdata handshake. wstrb 4'b0000 means read; 4'b1111 means word write.
- Registers the granted request toward the slave, sequences exactly one slave transaction at a time, and routes ready back to the winner.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the on-chip BRAM bus.
// m0 is the instruction-fetch port and m1 is the load/store port.
// The granted request is registered toward the slave. Only one slave
// transaction is in flight at a time, and each is followed by one idle
// RELEASE cycle.
// Optional feature: define ARB_TIMEOUT_EN to add a per-transaction watchdog.
// The watchdog aborts a stuck slave access after TIMEOUT_CYCLES BUSY cycles.

module mem_bus_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,

    output logic [31:0] m_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_t;

    state_t      r_state;
    logic        r_s_valid;
    logic [31:0] r_s_addr;
    logic [31:0] r_s_wdata;
    logic [3:0]  r_s_wstrb;
    logic        r_grant;
    logic        r_last_grant;

    logic        w_pick_m1;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_timeout;
    logic        w_done;

    // m1 wins when it asks alone, or on a tie when round-robin says m0 had the last turn.
    assign w_pick_m1 = m1_valid &&
                       (!m0_valid || ((FIXED_PRIORITY == 0) && !r_last_grant));

    assign w_addr  = w_pick_m1 ? m1_addr  : m0_addr;
    assign w_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
    assign w_wstrb = w_pick_m1 ? m1_wstrb : m0_wstrb;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] r_cnt;

    // Watchdog counter: zero outside BUSY, counts BUSY cycles without s_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state != StBusy) begin
            r_cnt <= '0;
        end else if (!s_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A real s_ready in the limit cycle takes precedence over the abort.
    assign w_timeout = (r_state == StBusy) && !s_ready &&
                       (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    assign w_done = (r_state == StBusy) && (s_ready || w_timeout);

    assign m0_ready = w_done && !r_grant;
    assign m1_ready = w_done && r_grant;
    assign m_rdata  = w_timeout ? 32'hDEAD_BEEF : s_rdata;
    assign bus_err  = w_timeout;

    assign s_valid = r_s_valid;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign s_wstrb = r_s_wstrb;
    assign grant   = r_grant;

    // Arbitration FSM: IDLE picks and latches a winner, BUSY waits, RELEASE idles one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_s_valid    <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_wstrb    <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (m0_valid || m1_valid) begin
                        r_s_addr     <= w_addr;
                        r_s_wdata    <= w_wdata;
                        r_s_wstrb    <= w_wstrb;
                        r_grant      <= w_pick_m1;
                        r_last_grant <= w_pick_m1;
                        r_s_valid    <= 1'b1;
                        r_state      <= StBusy;
                    end
                end
                StBusy: begin
                    if (w_done) begin
                        r_s_valid <= 1'b0;
                        r_state   <= StRelease;
                    end
                end
                StRelease: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_s_valid <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter.
// u_dut is the round-robin instance and sits in front of a BRAM model.
// u_fp is a fixed-priority instance that sees the same master inputs.
// It is only watched during the tie test.
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TbTimeout = 8;
`else
    localparam int unsigned TbTimeout = 64;
`endif

    typedef struct {
        logic        m;
        logic [31:0] data;
        logic        chk;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready, s_valid, grant, bus_err;
    logic [31:0] m_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;

    logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_grant, fp_bus_err;
    logic [31:0] fp_m_rdata, fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;
    logic        fp_s_ready = 1'b0;
    logic [31:0] fp_s_rdata = '0;

    logic [31:0] mem [0:63];
    logic        bram_en = 1'b1;
    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          low_run = 0;
    int          last_gap = -1;
    logic        fp_window = 1'b0;
    int          fp_m0_cnt = 0;
    int          fp_m1_cnt = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TbTimeout)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .bus_err(bus_err)
    );

    mem_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(64)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m_rdata(fp_m_rdata),
        .s_valid(fp_s_valid), .s_ready(fp_s_ready), .s_addr(fp_s_addr),
        .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb), .s_rdata(fp_s_rdata),
        .grant(fp_grant), .bus_err(fp_bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] data, input logic c,
                        input logic e);
        exp_t x;
        x.m = m; x.data = data; x.chk = c; x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic start_req(input logic m, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        @(negedge clk);
        if (m) begin
            m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
        end else begin
            m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
        end
    endtask

    // Wait for the given master's ready, then drop its valid in the same sample slot.
    task automatic wait_ready(input logic m, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (m ? m1_ready : m0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout_m%0d: got no ready, expected one within 100 cycles", m);
        end
        if (m) m1_valid = 1'b0;
        else   m0_valid = 1'b0;
    endtask

    // BRAM model behind u_dut: answers on the second cycle of s_valid and applies byte strobes.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (s_ready) begin
                s_ready = 1'b0;
                cnt = 0;
            end else if (s_valid && bram_en) begin
                if (cnt == 1) begin
                    s_ready = 1'b1;
                    s_rdata = mem[s_addr[7:2]];
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                end else begin
                    cnt++;
                end
            end else if (!s_valid) begin
                cnt = 0;
            end
        end
    end

    // Read-only responder behind u_fp with the same timing.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fp_s_ready) begin
                fp_s_ready = 1'b0;
                cnt = 0;
            end else if (fp_s_valid) begin
                if (cnt == 1) begin
                    fp_s_ready = 1'b1;
                    fp_s_rdata = mem[fp_s_addr[7:2]];
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ready pulse and tracks s_valid gaps.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (m0_ready || m1_ready) begin
                    chk("single_ready", {31'd0, m0_ready && m1_ready}, 32'd0);
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ready: got m0=%b m1=%b, expected none",
                                 m0_ready, m1_ready);
                    end else begin
                        e = sb_q.pop_front();
                        chk("ready_master", {31'd0, m1_ready}, {31'd0, e.m});
                        chk("grant", {31'd0, grant}, {31'd0, e.m});
                        if (e.chk) chk("rdata", m_rdata, e.data);
                        chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    end
                end else if (bus_err) begin
                    chk("bus_err_without_ready", {31'd0, bus_err}, 32'd0);
                end
                if (fp_window && fp_m1_ready) fp_m1_cnt++;
                if (fp_window && fp_m0_ready) begin
                    fp_m0_cnt++;
                    chk("fp_rdata", fp_m_rdata, 32'd0);
                    chk("fp_bus_err", {31'd0, fp_bus_err}, 32'd0);
                end
                if (!s_valid) begin
                    low_run++;
                end else begin
                    if (low_run != 0) last_gap = low_run;
                    low_run = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        int done;
        for (int i = 0; i < 64; i++) mem[i] = i;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        chk("rst_grant", {31'd0, grant}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        reset_n = 1'b1;

        // m0 reads 0x10 alone
        start_req(1'b0, 32'h10, 32'h0, 4'b0000);
        push(1'b0, 32'h4, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h10);
        chk("t1_grant", {31'd0, grant}, 32'd0);
        wait_ready(1'b0, w);

        // m1 writes then reads 0x20
        start_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111);
        push(1'b1, 32'h0, 1'b0, 1'b0);
        wait_ready(1'b1, w);
        start_req(1'b1, 32'h20, 32'h0, 4'b0000);
        push(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
        wait_ready(1'b1, w);
        chk("t2_gap", last_gap, 32'd2);

        // Both request continuously: round-robin alternates, fixed priority keeps m0
        @(negedge clk);
        m0_addr = 32'h0; m0_wstrb = 4'b0000; m0_valid = 1'b1;
        m1_addr = 32'h4; m1_wstrb = 4'b0000; m1_valid = 1'b1;
        fp_window = 1'b1;
        push(1'b0, 32'h0, 1'b1, 1'b0);
        push(1'b1, 32'h1, 1'b1, 1'b0);
        push(1'b0, 32'h0, 1'b1, 1'b0);
        push(1'b1, 32'h1, 1'b1, 1'b0);
        done = 0;
        for (int i = 0; i < 200 && done < 4; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) done++;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        fp_window = 1'b0;
        chk("t3_rr_done", done, 32'd4);
        chk("t3_fp_m1_grants", fp_m1_cnt, 32'd0);
        chk("t3_fp_m0_served", {31'd0, fp_m0_cnt >= 2}, 32'd1);

        // Reset during BUSY on an m0 request, then a tie must go to m0
        repeat (4) @(negedge clk);
        bram_en = 1'b0;
        start_req(1'b0, 32'h8, 32'h0, 4'b0000);
        repeat (2) @(negedge clk);
        chk("t4_busy", {31'd0, s_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("t4_rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("t4_rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        m0_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bram_en = 1'b1;
        @(negedge clk);
        m0_addr = 32'hC;  m0_wstrb = 4'b0000; m0_valid = 1'b1;
        m1_addr = 32'h14; m1_wstrb = 4'b0000; m1_valid = 1'b1;
        push(1'b0, 32'h3, 1'b1, 1'b0);
        push(1'b1, 32'h5, 1'b1, 1'b0);
        wait_ready(1'b0, w);
        wait_ready(1'b1, w);

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: the watchdog fires on the 8th BUSY cycle
        repeat (3) @(negedge clk);
        bram_en = 1'b0;
        start_req(1'b0, 32'h4, 32'h0, 4'b0000);
        push(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        wait_ready(1'b0, w);
        chk("t5_timeout_cycle", w, 32'd8);
        @(negedge clk);
        chk("t5_release_s_valid", {31'd0, s_valid}, 32'd0);
        chk("t5_release_bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        chk("t5_idle_s_valid", {31'd0, s_valid}, 32'd0);
        bram_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
